// File: rtl/bcd_serial_adder_pkg.sv
// Shared constants for the digit-serial BCD adder: digit width,
// decimal correction value and FSM state encodings.
package bcd_serial_adder_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_CORR = 4'd6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/bcd_serial_adder_digit.sv
// Combinational single-digit BCD add: binary sum plus a +6 correction whenever
// the binary result exceeds 9 or overflows 4 bits. Illegal digits are not saturated.
module bcd_digit_add
  import bcd_serial_adder_pkg::*;
(
  input  logic [BCD_W-1:0] x,
  input  logic [BCD_W-1:0] y,
  input  logic             c,
  output logic [BCD_W-1:0] d,
  output logic             co
);

  logic [BCD_W:0] w_z;
  logic           w_dc;

  assign w_z  = {1'b0, x} + {1'b0, y} + {{BCD_W{1'b0}}, c};
  assign w_dc = w_z[4] | (w_z[3] & w_z[2]) | (w_z[3] & w_z[1]);
  assign d    = w_dc ? (w_z[BCD_W-1:0] + BCD_CORR) : w_z[BCD_W-1:0];
  assign co   = w_dc;

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder: one digit pair per clock, LSD first,
// with the decimal carry held in a flop between digits.
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BCD_W*DIGITS-1:0] a,
  input  logic [BCD_W*DIGITS-1:0] b,
  input  logic                    cin,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] sum,
  output logic                    cout,
  output logic                    err
);

  localparam int W     = BCD_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [1:0]       r_state;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_err;
  logic [IDX_W-1:0] r_idx;

  logic [BCD_W-1:0] w_d;
  logic             w_co;
  logic             w_last;
  logic             w_dig_err;
  logic [W-1:0]     w_sum_next;

  bcd_digit_add u_digit (
    .x  (r_a[BCD_W-1:0]),
    .y  (r_b[BCD_W-1:0]),
    .c  (r_carry),
    .d  (w_d),
    .co (w_co)
  );

  assign w_last    = (r_idx == IDX_W'(DIGITS - 1));
  assign w_dig_err = (r_a[BCD_W-1:0] > 4'd9) | (r_b[BCD_W-1:0] > 4'd9);

  // Result digits enter at the MSD end so that after DIGITS shifts digit 0 sits at the LSD.
  generate
    if (DIGITS == 1) begin : g_one
      assign w_sum_next = w_d;
    end else begin : g_many
      assign w_sum_next = {w_d, r_sum[W-1:BCD_W]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum   <= w_sum_next;
          r_a     <= r_a >> BCD_W;
          r_b     <= r_b >> BCD_W;
          r_carry <= w_co;
          r_err   <= r_err | w_dig_err;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_cout  <= w_co;
            r_state <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign err  = r_err;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed testbench for bcd_serial_adder (DIGITS=4) with hand-computed sums.
module tb_bcd_serial_adder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        err;

  int n_total;
  int n_bad;

  bcd_serial_adder #(.DIGITS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation and follow it to the done pulse, checking timing and results.
  task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, input logic [15:0] es, input logic ec, input logic ee);
    int cyc;
    int nbusy;
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    nbusy = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy) nbusy++;
      if (done) break;
    end
    chk({tag, "_lat"}, cyc, 5);
    chk({tag, "_busy"}, nbusy, 4);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_err"}, err, ee);
    @(negedge clk);
    chk({tag, "_pulse"}, done, 1'b0);
    chk({tag, "_hold"}, sum, es);
  endtask

  initial begin
    int ndone;
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_cout", cout, 1'b0);
    chk("rst_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_op("basic", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    run_op("ripple", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("ripcin", 16'h9999, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("cinonly", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    run_op("mix", 16'h4999, 16'h5000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("illegal", 16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b1);

    // start re-pulsed while busy must be ignored
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done) ndone++;
      if (i == 1 || i == 2) begin
        a = 16'h9999; b = 16'h9999; cin = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (i == 5) begin
        chk("ign_sum", sum, 16'h6912);
        chk("ign_cout", cout, 1'b0);
      end
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_idle", busy, 1'b0);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ab_busy_pre", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("ab_busy", busy, 1'b0);
    chk("ab_sum", sum, 16'h0000);
    chk("ab_cout", cout, 1'b0);
    chk("ab_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("ab_quiet", ndone, 0);
    run_op("fresh", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
